// File: rtl/vedacao_multicabecote_pkg.sv
// Shared types and default timing for the multi-head cork sealer.
// ST_ERRO only exists when VEDACAO_WATCHDOG_EN is defined.
package vedacao_multicabecote_pkg;

  localparam int DEF_NUM_HEADS     = 2;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_TIMER_W       = 26;
  localparam int DEF_TEMPO_VEDACAO = 25000000;
  localparam int DEF_TEMPO_WDOG    = 100000000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_VEDANDO   = 3'd1,
    ST_CONCLUIDO = 3'd2,
    ST_ABORTADO  = 3'd3
`ifdef VEDACAO_WATCHDOG_EN
    , ST_ERRO    = 3'd4
`endif
  } estado_e;

  // Bits needed to hold a head count of 0..n.
  function automatic int qty_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vedacao_multicabecote_if.sv
// Sequencer/stock/CQ side bundle of the sealer; master drives commands, slave is the controller.
interface vedacao_multicabecote_if
  import vedacao_multicabecote_pkg::*;
#(
  parameter int NUM_HEADS = DEF_NUM_HEADS,
  parameter int CNT_W     = DEF_CNT_W
);
  localparam int QW = qty_width(NUM_HEADS);

  logic                 cmd_iniciar;
  logic [NUM_HEADS-1:0] head_mask;
  logic [CNT_W-1:0]     rolhas_disp;
  logic                 abortar;
  logic                 cq_concluido;
  logic [NUM_HEADS-1:0] vedacao_ativa;
  logic                 decrementar_rolha;
  logic [QW-1:0]        qtd_decremento;
  logic                 falta_rolha;
  logic                 tarefa_concluida;
  logic                 abortado;
  logic                 erro_wdog;

  modport master (
    output cmd_iniciar, head_mask, rolhas_disp, abortar, cq_concluido,
    input  vedacao_ativa, decrementar_rolha, qtd_decremento, falta_rolha,
           tarefa_concluida, abortado, erro_wdog
  );

  modport slave (
    input  cmd_iniciar, head_mask, rolhas_disp, abortar, cq_concluido,
    output vedacao_ativa, decrementar_rolha, qtd_decremento, falta_rolha,
           tarefa_concluida, abortado, erro_wdog
  );

endinterface

// File: rtl/vedacao_multicabecote_popcount_mask.sv
// Combinational count of set bits in a head mask; shared with the CQ stage.
module popcount_mask #(
  parameter int NUM_HEADS = 2,
  parameter int QW        = 2
) (
  input  logic [NUM_HEADS-1:0] mask_i,
  output logic [QW-1:0]        count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_HEADS; i++) begin
      count_o = count_o + QW'(mask_i[i]);
    end
  end

endmodule

// File: rtl/vedacao_multicabecote.sv
// Multi-head cork sealing controller: stock check, timed seal, abort and CQ handshake.
// Optional CONCLUIDO watchdog enabled by defining VEDACAO_WATCHDOG_EN.
module vedacao_multicabecote
  import vedacao_multicabecote_pkg::*;
#(
  parameter int NUM_HEADS     = DEF_NUM_HEADS,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int TIMER_W       = DEF_TIMER_W,
  parameter int TEMPO_VEDACAO = DEF_TEMPO_VEDACAO,
  parameter int TEMPO_WDOG    = DEF_TEMPO_WDOG
) (
  input logic                    clk,
  input logic                    reset,
  vedacao_multicabecote_if.slave bus
);

  localparam int QW = qty_width(NUM_HEADS);
  localparam int CW = (CNT_W > QW) ? CNT_W : QW;

  estado_e              state_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [NUM_HEADS-1:0] ativa_q;
  logic                 dec_q;
  logic [QW-1:0]        qtd_q;
  logic                 falta_q;
  logic                 concl_q;
  logic                 abort_q;

  logic [QW-1:0]        pop_d;
  logic                 start_req_d;
  logic                 stock_ok_d;

  popcount_mask #(.NUM_HEADS(NUM_HEADS), .QW(QW)) u_popcount (
    .mask_i  (bus.head_mask),
    .count_o (pop_d)
  );

  assign start_req_d = bus.cmd_iniciar & ~bus.abortar & (|bus.head_mask);
  assign stock_ok_d  = CW'(pop_d) <= CW'(bus.rolhas_disp);

`ifdef VEDACAO_WATCHDOG_EN
  localparam int WDOG_W = $clog2(TEMPO_WDOG + 1);
  logic [WDOG_W-1:0] wdog_q;
  logic              erro_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      ativa_q <= '0;
      dec_q   <= 1'b0;
      qtd_q   <= '0;
      falta_q <= 1'b0;
      concl_q <= 1'b0;
      abort_q <= 1'b0;
`ifdef VEDACAO_WATCHDOG_EN
      wdog_q  <= '0;
      erro_q  <= 1'b0;
`endif
    end else begin
      // Decrement request is a single-cycle strobe.
      dec_q <= 1'b0;
      qtd_q <= '0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (start_req_d) begin
            if (stock_ok_d) begin
              state_q <= ST_VEDANDO;
              ativa_q <= bus.head_mask;
              dec_q   <= 1'b1;
              qtd_q   <= pop_d;
              falta_q <= 1'b0;
            end else begin
              falta_q <= 1'b1;
            end
          end
        end
        ST_VEDANDO: begin
          if (bus.abortar) begin
            state_q <= ST_ABORTADO;
            ativa_q <= '0;
            abort_q <= 1'b1;
          end else if (timer_q == TIMER_W'(TEMPO_VEDACAO - 1)) begin
            state_q <= ST_CONCLUIDO;
            ativa_q <= '0;
            concl_q <= 1'b1;
            timer_q <= '0;
`ifdef VEDACAO_WATCHDOG_EN
            wdog_q  <= '0;
`endif
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_ABORTADO: begin
          if (!bus.cmd_iniciar && !bus.abortar) begin
            state_q <= ST_IDLE;
            abort_q <= 1'b0;
          end
        end
        ST_CONCLUIDO: begin
          if (!bus.cmd_iniciar && bus.cq_concluido) begin
            state_q <= ST_IDLE;
            concl_q <= 1'b0;
          end
`ifdef VEDACAO_WATCHDOG_EN
          else if (wdog_q == WDOG_W'(TEMPO_WDOG - 1)) begin
            state_q <= ST_ERRO;
            concl_q <= 1'b0;
            falta_q <= 1'b0;
            erro_q  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
`endif
        end
`ifdef VEDACAO_WATCHDOG_EN
        ST_ERRO: begin
          state_q <= ST_ERRO;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          ativa_q <= '0;
          concl_q <= 1'b0;
          abort_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vedacao_ativa     = ativa_q;
  assign bus.decrementar_rolha = dec_q;
  assign bus.qtd_decremento    = qtd_q;
  assign bus.falta_rolha       = falta_q;
  assign bus.tarefa_concluida  = concl_q;
  assign bus.abortado          = abort_q;

`ifdef VEDACAO_WATCHDOG_EN
  assign bus.erro_wdog = erro_q;
`else
  assign bus.erro_wdog = 1'b0;
  wire unused_tempo_wdog = ^TEMPO_WDOG;
`endif

endmodule

// File: tb/tb_vedacao_multicabecote.sv
// Randomised + directed bench for vedacao_multicabecote with an event-level reference model and scoreboard.
module tb_vedacao_multicabecote;

  localparam int NH = 4;
  localparam int CW = 8;
  localparam int TV = 4;
  localparam int TW = 8;
  localparam int QW = 3;

  typedef struct packed {
    logic [NH-1:0] ativa;
    logic          dec;
    logic [QW-1:0] qtd;
    logic          falta;
    logic          concl;
    logic          abrt;
    logic          err;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vedacao_multicabecote_if #(.NUM_HEADS(NH), .CNT_W(CW)) bus ();

  vedacao_multicabecote #(
    .NUM_HEADS(NH), .CNT_W(CW), .TIMER_W(8), .TEMPO_VEDACAO(TV), .TEMPO_WDOG(TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: remaining seal cycles plus a few status flags.
  int            seal_left;
  int            done_cycles;
  bit            m_done, m_aborted, m_falta, m_err;
  logic [NH-1:0] cur_mask;

  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   started = 1'b0;
  event imm_ev;

  function automatic out_t zero_out();
    out_t o;
    o = '0;
    return o;
  endfunction

  task automatic model_clear();
    seal_left = 0; done_cycles = 0;
    m_done = 0; m_aborted = 0; m_falta = 0; m_err = 0;
    cur_mask = '0;
  endtask

  // Advance the model over one rising edge using the inputs currently applied.
  task automatic model_step(input bit cmd, input logic [NH-1:0] mask, input int stock,
                            input bit ab, input bit cq, output out_t o);
    bit pulse;
    int heads;
    pulse = 0;
    heads = $countones(mask);
    if (m_err) begin
    end else if (seal_left > 0) begin
      if (ab) begin
        seal_left = 0;
        m_aborted = 1;
      end else begin
        seal_left--;
        if (seal_left == 0) begin
          m_done = 1;
          done_cycles = 0;
        end
      end
    end else if (m_aborted) begin
      if (!cmd && !ab) m_aborted = 0;
    end else if (m_done) begin
      if (!cmd && cq) m_done = 0;
      else begin
        done_cycles++;
`ifdef VEDACAO_WATCHDOG_EN
        if (done_cycles == TW) begin
          m_done = 0; m_err = 1; m_falta = 0;
        end
`endif
      end
    end else if (cmd && !ab && mask != '0) begin
      if (heads <= stock) begin
        seal_left = TV;
        cur_mask = mask;
        pulse = 1;
        m_falta = 0;
      end else begin
        m_falta = 1;
      end
    end
    o.ativa = (seal_left > 0) ? cur_mask : '0;
    o.dec   = pulse;
    o.qtd   = pulse ? QW'(heads) : '0;
    o.falta = m_falta;
    o.concl = m_done;
    o.abrt  = m_aborted;
    o.err   = m_err;
  endtask

  // Called at a falling edge: apply inputs, predict the next edge, wait for the next falling edge.
  task automatic cyc(input bit cmd, input logic [NH-1:0] mask, input int stock,
                     input bit ab, input bit cq);
    out_t o;
    bus.cmd_iniciar  = cmd;
    bus.head_mask    = mask;
    bus.rolhas_disp  = CW'(stock);
    bus.abortar      = ab;
    bus.cq_concluido = cq;
    model_step(cmd, mask, stock, ab, cq, o);
    exp_q.push_back(o);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit cq);
    repeat (n) cyc(1'b0, '0, 10, 1'b0, cq);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    model_clear();
    exp_q.push_back(zero_out());
    -> imm_ev;
    repeat (n) begin
      exp_q.push_back(zero_out());
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  // Monitor: compares every output after each rising edge and right after an async reset.
  initial begin
    out_t e;
    out_t a;
    forever begin
      @(posedge clk or imm_ev);
      #1;
      if (exp_q.size() == 0) begin
        if (started) begin
          n_bad++;
          $display("FAIL scoreboard_empty at %0t: DUT output present but no expected entry", $time);
        end
      end else begin
        e = exp_q.pop_front();
        a.ativa = bus.vedacao_ativa;
        a.dec   = bus.decrementar_rolha;
        a.qtd   = bus.qtd_decremento;
        a.falta = bus.falta_rolha;
        a.concl = bus.tarefa_concluida;
        a.abrt  = bus.abortado;
        a.err   = bus.erro_wdog;
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs at %0t: got ativa=%b dec=%b qtd=%0d falta=%b concl=%b abrt=%b err=%b, expected ativa=%b dec=%b qtd=%0d falta=%b concl=%b abrt=%b err=%b",
                   $time, a.ativa, a.dec, a.qtd, a.falta, a.concl, a.abrt, a.err,
                   e.ativa, e.dec, e.qtd, e.falta, e.concl, e.abrt, e.err);
        end
      end
    end
  end

  initial begin
    bus.cmd_iniciar  = 1'b0;
    bus.head_mask    = '0;
    bus.rolhas_disp  = '0;
    bus.abortar      = 1'b0;
    bus.cq_concluido = 1'b0;
    model_clear();
    @(negedge clk);
    started = 1'b1;
    apply_reset(2);

    // Basic seal: two heads, ample stock, then CQ release.
    cyc(1, 4'b0101, 10, 0, 0);
    idle(6, 0);
    idle(1, 1);
    idle(1, 0);

    // Stock shortfall held, then accepted once stock suffices.
    cyc(1, 4'b1111, 3, 0, 0);
    cyc(1, 4'b1111, 3, 0, 0);
    cyc(0, 4'b0000, 3, 0, 0);
    cyc(1, 4'b1111, 4, 0, 0);
    idle(5, 0);
    idle(1, 1);

    // Abort on third sealing cycle, held while cmd/abort stay high.
    cyc(1, 4'b0011, 5, 0, 0);
    cyc(1, 4'b0011, 5, 0, 0);
    cyc(1, 4'b0011, 5, 0, 0);
    cyc(1, 4'b0011, 5, 1, 0);
    cyc(1, 4'b0011, 5, 0, 0);
    cyc(0, 4'b0000, 5, 1, 0);
    idle(2, 0);

    // Abort on first and on last sealing cycle.
    cyc(1, 4'b0001, 5, 0, 0);
    cyc(0, 4'b0000, 5, 1, 0);
    idle(2, 0);
    cyc(1, 4'b0010, 5, 0, 0);
    idle(3, 0);
    cyc(0, 4'b0000, 5, 1, 0);
    idle(2, 0);

    // CQ done but cmd still high holds CONCLUIDO; restart afterwards.
    cyc(1, 4'b1000, 5, 0, 0);
    idle(4, 0);
    repeat (3) cyc(1, 4'b1000, 5, 0, 1);
    cyc(0, 4'b0000, 5, 0, 1);
    cyc(1, 4'b0110, 5, 0, 0);
    idle(4, 0);
    idle(1, 1);

    // Empty mask ignored, abort blocks start, zero stock refused.
    cyc(1, 4'b0000, 5, 0, 0);
    cyc(1, 4'b0000, 5, 0, 0);
    cyc(1, 4'b0011, 5, 1, 0);
    cyc(1, 4'b0001, 0, 0, 0);
    idle(2, 0);

    // Reset in the middle of a seal.
    cyc(1, 4'b1001, 5, 0, 0);
    idle(2, 0);
    apply_reset(2);
    idle(3, 0);

    // Long stay in CONCLUIDO (trips the watchdog when built in).
    cyc(1, 4'b0001, 5, 0, 0);
    idle(4, 0);
    idle(10, 0);
    apply_reset(1);
    idle(1, 0);

    // Randomised traffic.
    repeat (3000) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset($urandom_range(1, 2));
      end else begin
        cyc($urandom_range(0, 3) != 0, NH'($urandom_range(0, 15)), $urandom_range(0, 5),
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
